// File: rtl/ahb_bus_arbiter.sv
// Round-robin, burst-aware arbiter sharing the single AHB slave port of the
// AHB-to-APB bridge between N_MST masters, with separate address/data owners.
module ahb_bus_arbiter #(
    parameter int N_MST = 2,
    parameter int MW    = 1
) (
    input  logic                clock,
    input  logic                Hreset,
    input  logic [N_MST-1:0]    M_Hbusreq,
    output logic [N_MST-1:0]    M_Hgrant,
    input  logic [N_MST*32-1:0] M_Haddr,
    input  logic [N_MST*2-1:0]  M_Htrans,
    input  logic [N_MST-1:0]    M_Hwrite,
    input  logic [N_MST*3-1:0]  M_Hsize,
    input  logic [N_MST*3-1:0]  M_Hburst,
    input  logic [N_MST*32-1:0] M_Hwdata,
    output logic                M_Hready,
    output logic [31:0]         Haddr,
    output logic                Hwrite,
    output logic [2:0]          Hsize,
    output logic [2:0]          Hburst,
    output logic [1:0]          Htrans,
    output logic [31:0]         Hwdata,
    output logic                Hreadyin,
    input  logic                Hreadyout,
    input  logic [1:0]          Hresp,
    output logic [MW-1:0]       Hmaster,
    output logic [MW-1:0]       Hmaster_data
);

    localparam int AW = 32;
    localparam int TW = 2;
    localparam int CW = 3;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] BR_INCR   = 3'b001;
    localparam logic [1:0] RESP_ERR  = 2'b01;

    logic [MW-1:0] addr_owner_r;
    logic [MW-1:0] data_owner_r;
    logic [MW-1:0] rr_ptr_r;
    logic [3:0]    burst_cnt_r;
    logic          in_incr_r;

    int            own_sel_s;
    int            dat_sel_s;
    logic [1:0]    own_trans_s;
    logic [2:0]    own_burst_s;
    logic          own_req_s;
    logic [3:0]    burst_cnt_nxt_s;
    logic          in_incr_nxt_s;
    logic          cnt_done_s;
    logic          rearb_ok_s;
    logic [MW-1:0] winner_s;
    logic [MW-1:0] cand_s;
    logic          found_s;
    logic          hit_s;

    // Remaining beats after the first one of a fixed-length burst; 0 otherwise.
    function automatic logic [3:0] burst_len_f(input logic [2:0] burst);
        logic [3:0] len;
        case (burst[2:1])
            2'b01:   len = 4'd3;
            2'b10:   len = 4'd7;
            2'b11:   len = 4'd15;
            default: len = 4'd0;
        endcase
        return len;
    endfunction

    function automatic logic [N_MST-1:0] onehot_f(input logic [MW-1:0] idx);
        logic [N_MST-1:0] v;
        for (int i = 0; i < N_MST; i++) begin
            v[i] = (idx == MW'(i));
        end
        return v;
    endfunction

    assign own_sel_s   = int'(addr_owner_r);
    assign dat_sel_s   = int'(data_owner_r);
    assign own_trans_s = M_Htrans[TW*own_sel_s +: TW];
    assign own_burst_s = M_Hburst[CW*own_sel_s +: CW];
    assign own_req_s   = M_Hbusreq[addr_owner_r];

    assign Haddr        = M_Haddr[AW*own_sel_s +: AW];
    assign Hwrite       = M_Hwrite[addr_owner_r];
    assign Hsize        = M_Hsize[CW*own_sel_s +: CW];
    assign Hburst       = own_burst_s;
    assign Htrans       = own_trans_s;
    assign Hwdata       = M_Hwdata[AW*dat_sel_s +: AW];
    assign M_Hready     = Hreadyout;
    assign Hreadyin     = Hreadyout;
    assign Hmaster      = addr_owner_r;
    assign Hmaster_data = data_owner_r;
    assign M_Hgrant     = onehot_f(addr_owner_r);

    // Burst bookkeeping: fixed-burst beat counter and undefined-INCR flag.
    always_comb begin
        burst_cnt_nxt_s = burst_cnt_r;
        in_incr_nxt_s   = in_incr_r;
        if (Hreadyout == 1'b0) begin
            if (Hresp == RESP_ERR) begin
                burst_cnt_nxt_s = 4'd0;
                in_incr_nxt_s   = 1'b0;
            end else begin
                burst_cnt_nxt_s = burst_cnt_r;
                in_incr_nxt_s   = in_incr_r;
            end
        end else begin
            case (own_trans_s)
                TR_NONSEQ: burst_cnt_nxt_s = burst_len_f(own_burst_s);
                TR_SEQ:    burst_cnt_nxt_s = (burst_cnt_r != 4'd0) ? (burst_cnt_r - 4'd1) : 4'd0;
                default:   burst_cnt_nxt_s = burst_cnt_r;
            endcase
            if ((own_trans_s != TR_IDLE) && (own_burst_s == BR_INCR)) begin
                in_incr_nxt_s = 1'b1;
            end else if ((own_trans_s == TR_IDLE) || (own_trans_s == TR_NONSEQ)) begin
                in_incr_nxt_s = 1'b0;
            end else begin
                in_incr_nxt_s = in_incr_r;
            end
        end
    end

    // The SEQ beat taking the counter from 1 to 0 already permits handover.
    assign cnt_done_s = (burst_cnt_r == 4'd0) ||
                        ((own_trans_s == TR_SEQ) && (burst_cnt_r == 4'd1));
    assign rearb_ok_s = Hreadyout && cnt_done_s && (own_trans_s != TR_BUSY) &&
                        !(in_incr_r && own_req_s);

    // Round-robin search starting after rr_ptr, rr_ptr itself last; park if none.
    always_comb begin
        winner_s = addr_owner_r;
        found_s  = 1'b0;
        cand_s   = {MW{1'b0}};
        hit_s    = 1'b0;
        for (int k = 1; k <= N_MST; k++) begin
            cand_s   = MW'((int'(rr_ptr_r) + k) % N_MST);
            hit_s    = !found_s && M_Hbusreq[cand_s];
            winner_s = hit_s ? cand_s : winner_s;
            found_s  = found_s | hit_s;
        end
    end

    // Burst state register; a reset abandons any burst in progress.
    always_ff @(posedge clock or posedge Hreset) begin
        if (Hreset) begin
            burst_cnt_r <= 4'd0;
            in_incr_r   <= 1'b0;
        end else begin
            burst_cnt_r <= burst_cnt_nxt_s;
            in_incr_r   <= in_incr_nxt_s;
        end
    end

    // Ownership registers: address owner, data-phase owner, round-robin pointer.
    always_ff @(posedge clock or posedge Hreset) begin
        if (Hreset) begin
            addr_owner_r <= {MW{1'b0}};
            data_owner_r <= {MW{1'b0}};
            rr_ptr_r     <= {MW{1'b0}};
        end else begin
            if (Hreadyout) begin
                data_owner_r <= addr_owner_r;
            end
            if (rearb_ok_s) begin
                addr_owner_r <= winner_s;
                if (winner_s != addr_owner_r) begin
                    rr_ptr_r <= winner_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: directed vector table, hand-written
// multi-cycle sequences, then random stimulus against a behavioural model.
module tb_ahb_bus_arbiter;

    localparam int N_MST = 2;
    localparam int MW    = 1;

    localparam logic [1:0] TI = 2'b00, TB = 2'b01, TN = 2'b10, TS = 2'b11;
    localparam logic [2:0] B_S = 3'b000, B_INC = 3'b001, B_I4 = 3'b011,
                           B_I8 = 3'b101, B_I16 = 3'b111;
    localparam logic [1:0] OK = 2'b00, ERR = 2'b01;

    logic clock = 1'b0;
    logic Hreset;
    always #5 clock = ~clock;

    logic [1:0]  req;
    logic [1:0]  trans [N_MST];
    logic [2:0]  burst [N_MST];
    logic [31:0] addr  [N_MST];
    logic [31:0] wdata [N_MST];
    logic [2:0]  size  [N_MST];
    logic        wr    [N_MST];
    logic        ready;
    logic [1:0]  resp;

    logic [N_MST-1:0]    M_Hgrant;
    logic                M_Hready;
    logic [31:0]         Haddr, Hwdata;
    logic                Hwrite, Hreadyin;
    logic [2:0]          Hsize, Hburst;
    logic [1:0]          Htrans;
    logic [MW-1:0]       Hmaster, Hmaster_data;

    ahb_bus_arbiter #(.N_MST(N_MST), .MW(MW)) dut (
        .clock(clock), .Hreset(Hreset),
        .M_Hbusreq(req), .M_Hgrant(M_Hgrant),
        .M_Haddr({addr[1], addr[0]}), .M_Htrans({trans[1], trans[0]}),
        .M_Hwrite({wr[1], wr[0]}), .M_Hsize({size[1], size[0]}),
        .M_Hburst({burst[1], burst[0]}), .M_Hwdata({wdata[1], wdata[0]}),
        .M_Hready(M_Hready), .Haddr(Haddr), .Hwrite(Hwrite), .Hsize(Hsize),
        .Hburst(Hburst), .Htrans(Htrans), .Hwdata(Hwdata), .Hreadyin(Hreadyin),
        .Hreadyout(ready), .Hresp(resp), .Hmaster(Hmaster), .Hmaster_data(Hmaster_data)
    );

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  t0;
        logic [2:0]  b0;
        logic [31:0] a0;
        logic [1:0]  t1;
        logic [2:0]  b1;
        logic [31:0] a1;
        logic        rdy;
        logic [1:0]  rsp;
        int          hm;
        int          hmd;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // behavioural model state
    int m_owner, m_downer, m_ptr, m_left;
    bit m_incr;
    int beats_tab [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic check_own(input string tag, input int hm, input int hmd);
        chk({tag, ".hmaster"}, 32'(Hmaster), 32'(hm));
        chk({tag, ".hmaster_data"}, 32'(Hmaster_data), 32'(hmd));
        chk({tag, ".grant"}, 32'(M_Hgrant), 32'(1 << hm));
        chk({tag, ".haddr"}, Haddr, addr[hm]);
        chk({tag, ".htrans"}, 32'(Htrans), 32'(trans[hm]));
        chk({tag, ".hwdata"}, Hwdata, wdata[hmd]);
    endtask

    function automatic vec_t mk(input logic [1:0] rq, input logic [1:0] t0, input logic [2:0] b0,
                                input logic [1:0] t1, input logic [2:0] b1, input logic rdy,
                                input logic [1:0] rsp, input int hm, input int hmd);
        vec_t v;
        v = '{rq, t0, b0, 32'h8000_0040, t1, b1, 32'h8000_0080, rdy, rsp, hm, hmd};
        return v;
    endfunction

    // Entered at posedge+1: drive the row, check at mid-cycle, advance one edge.
    task automatic apply(input vec_t v, input string tag);
        req = v.req;
        trans[0] = v.t0; burst[0] = v.b0; addr[0] = v.a0;
        trans[1] = v.t1; burst[1] = v.b1; addr[1] = v.a1;
        ready = v.rdy; resp = v.rsp;
        #4;
        check_own(tag, v.hm, v.hmd);
        @(posedge clock); #1;
    endtask

    task automatic idle_inputs();
        req = 2'b00; ready = 1'b1; resp = OK;
        for (int i = 0; i < N_MST; i++) begin
            trans[i] = TI; burst[i] = B_S; addr[i] = 32'h0000_0100 * (i + 1);
            size[i] = 3'b010; wr[i] = 1'b1;
        end
        wdata[0] = 32'hD000_0000; wdata[1] = 32'hD111_1111;
    endtask

    task automatic do_reset();
        idle_inputs();
        Hreset = 1'b1;
        @(posedge clock); #1;
        Hreset = 1'b0;
        m_owner = 0; m_downer = 0; m_ptr = 0; m_left = 0; m_incr = 1'b0;
    endtask

    // Model of one clock edge, from the arbitration rules on the sampled inputs.
    task automatic model_step();
        int o, best, bestd, d;
        bit done, ok;
        o = m_owner;
        if (!ready) begin
            if (resp == ERR) begin
                m_left = 0; m_incr = 1'b0;
            end
        end else begin
            done = (m_left == 0) || (trans[o] == TS && m_left == 1);
            ok = done && (trans[o] != TB) && !(m_incr && req[o]);
            best = o; bestd = N_MST + 1;
            for (int i = 0; i < N_MST; i++) begin
                if (req[i]) begin
                    d = (i - m_ptr - 1 + 2 * N_MST) % N_MST;
                    if (d < bestd) begin bestd = d; best = i; end
                end
            end
            m_downer = o;
            if (ok) begin
                if (best != o) m_ptr = best;
                m_owner = best;
            end
            if (trans[o] == TN) m_left = beats_tab[burst[o]] - 1;
            else if (trans[o] == TS && m_left > 0) m_left = m_left - 1;
            if (burst[o] == B_INC && trans[o] != TI) m_incr = 1'b1;
            else if (trans[o] == TI || trans[o] == TN) m_incr = 1'b0;
        end
    endtask

    vec_t tbl [11];

    initial begin
        tbl[0]  = '{2'b00, TI, B_S,  32'h0,         TI, B_S, 32'h0,         1'b1, OK, 0, 0};
        tbl[1]  = '{2'b11, TI, B_S,  32'h0,         TI, B_S, 32'h0,         1'b1, OK, 0, 0};
        tbl[2]  = '{2'b01, TI, B_S,  32'h0,         TN, B_S, 32'h8000_0000, 1'b1, OK, 1, 0};
        tbl[3]  = '{2'b01, TN, B_S,  32'h0000_1000, TI, B_S, 32'h8000_0000, 1'b1, OK, 0, 1};
        tbl[4]  = '{2'b00, TI, B_S,  32'h0,         TI, B_S, 32'h0,         1'b1, OK, 0, 0};
        tbl[5]  = '{2'b01, TN, B_I4, 32'h8000_0010, TI, B_S, 32'h0,         1'b1, OK, 0, 0};
        tbl[6]  = '{2'b11, TS, B_I4, 32'h8000_0014, TI, B_S, 32'h0,         1'b1, OK, 0, 0};
        tbl[7]  = '{2'b11, TS, B_I4, 32'h8000_0018, TI, B_S, 32'h0,         1'b1, OK, 0, 0};
        tbl[8]  = '{2'b11, TS, B_I4, 32'h8000_001C, TI, B_S, 32'h0,         1'b1, OK, 0, 0};
        tbl[9]  = '{2'b10, TI, B_S,  32'h0,         TI, B_S, 32'h0,         1'b1, OK, 1, 0};
        tbl[10] = '{2'b00, TI, B_S,  32'h0,         TI, B_S, 32'h0,         1'b1, OK, 1, 1};

        idle_inputs();
        Hreset = 1'b1;
        #3;
        check_own("reset", 0, 0);
        @(posedge clock); #1;
        Hreset = 1'b0;

        for (int i = 0; i < 11; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // INCR8 with three wait states on beat 3; M1 waits for the burst end
        do_reset();
        apply(mk(2'b01, TN, B_I8, TI, B_S, 1'b1, OK, 0, 0), "i8_b1");
        apply(mk(2'b01, TS, B_I8, TI, B_S, 1'b1, OK, 0, 0), "i8_b2");
        for (int i = 0; i < 3; i++) apply(mk(2'b11, TS, B_I8, TI, B_S, 1'b0, OK, 0, 0), "i8_wait");
        for (int i = 0; i < 6; i++) apply(mk(2'b11, TS, B_I8, TI, B_S, 1'b1, OK, 0, 0), $sformatf("i8_b%0d", i + 3));
        apply(mk(2'b11, TI, B_S, TI, B_S, 1'b1, OK, 1, 0), "i8_handover");

        // undefined-length INCR holds the grant while its owner keeps requesting
        do_reset();
        apply(mk(2'b10, TI, B_S, TI, B_S, 1'b1, OK, 0, 0), "incr_req");
        apply(mk(2'b10, TI, B_S, TN, B_INC, 1'b1, OK, 1, 0), "incr_ns");
        for (int i = 0; i < 3; i++) apply(mk(2'b11, TI, B_S, TS, B_INC, 1'b1, OK, 1, 1), "incr_hold");
        apply(mk(2'b01, TI, B_S, TI, B_S, 1'b1, OK, 1, 1), "incr_drop");
        apply(mk(2'b01, TI, B_S, TI, B_S, 1'b1, OK, 0, 1), "incr_handover");

        // ERROR on beat 2 of INCR16 releases the burst lock
        do_reset();
        apply(mk(2'b01, TN, B_I16, TI, B_S, 1'b1, OK, 0, 0), "err_b1");
        apply(mk(2'b11, TS, B_I16, TI, B_S, 1'b1, OK, 0, 0), "err_b2");
        apply(mk(2'b11, TS, B_I16, TI, B_S, 1'b0, ERR, 0, 0), "err_c1");
        apply(mk(2'b11, TI, B_S, TI, B_S, 1'b1, ERR, 0, 0), "err_c2");
        apply(mk(2'b10, TI, B_S, TI, B_S, 1'b1, OK, 1, 0), "err_handover");

        // asynchronous reset in the middle of a cycle while M1 owns the bus
        #2;
        Hreset = 1'b1;
        #1;
        check_own("async_rst", 0, 0);
        #2;
        Hreset = 1'b0;
        @(posedge clock); #1;

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            req = 2'($urandom);
            for (int i = 0; i < N_MST; i++) begin
                trans[i] = 2'($urandom); burst[i] = 3'($urandom);
                addr[i] = $urandom; wdata[i] = $urandom;
                size[i] = 3'($urandom); wr[i] = 1'($urandom);
            end
            ready = ($urandom_range(0, 3) != 0);
            resp = (!ready && $urandom_range(0, 2) == 0) ? ERR : OK;
            #4;
            check_own("rnd", m_owner, m_downer);
            chk("rnd.ready", 32'({M_Hready, Hreadyin}), 32'({ready, ready}));
            model_step();
            @(posedge clock); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
